pipe_add_sub: RTL
=================

PIPE_ADD_SUB -- requirements
Module: pipe_add_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter STAGES, default 4, number of pipeline stages; CHUNK = WIDTH/STAGES bits per stage.
REQ-003 SHALL have port clk, input, 1, single clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1, operand set present.
REQ-006 SHALL have port in_ready, output, 1, block accepts operands this cycle.
REQ-007 SHALL have port a, input, WIDTH, first operand.
REQ-008 SHALL have port b, input, WIDTH, second operand.
REQ-009 SHALL have port op, input, 2, operation: 0 ADD, 1 SUB, 2 ADC, 3 SBC.
REQ-010 SHALL have port cin, input, 1, carry-in used by ADC/SBC only.
REQ-011 SHALL have port out_valid, output, 1, result present.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-013 SHALL have port sum, output, WIDTH, result.
REQ-014 SHALL have port cout, output, 1, carry-out of MSB (SUB/SBC: 1 = no borrow).
REQ-015 SHALL have port ovf, output, 1, signed two's-complement overflow.
REQ-016 SHALL have port zero, output, 1, sum == 0.

Function
REQ-017 SHALL compute a + b' + c, b' = b (ADD/ADC) or ~b (SUB/SBC); c = 0 ADD, 1 SUB, cin ADC/SBC.
REQ-018 SHALL process CHUNK bits per stage, LSB chunk in stage 0; inter-stage carry registered; unprocessed operand chunks and finished sum chunks carried forward in stage registers.
REQ-019 SHALL have latency exactly STAGES cycles from accepted input (in_valid && in_ready) to out_valid with no backpressure; throughput one result per cycle.
REQ-020 SHALL compute ovf = carry into MSB XOR carry out of MSB; zero from full final sum.
REQ-021 SHALL implement per-stage valid bits; pipeline advances when final stage empty or out_ready = 1; otherwise all stages hold (global stall).
REQ-022 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-023 SHALL hold sum/cout/ovf/zero stable while out_valid && !out_ready.
REQ-024 SHALL accept input and deliver output in the same cycle when full and out_ready = 1 (no bubble).
REQ-025 SHALL wrap modulo 2^WIDTH; 0xFFFFFFFF + 1 -> sum 0, cout 1, zero 1.
REQ-026 SHALL reject (compile-time error) WIDTH % STAGES != 0 or STAGES < 1; STAGES = 1 is legal (latency 1).
REQ-027 SHALL ignore a, b, op, cin when in_valid = 0; bubbles propagate with valid = 0.

Reset
REQ-028 SHALL, on rising clk with rst_n = 0, clear all stage valid bits; out_valid = 0, sum = 0, cout = 0, ovf = 0, zero = 0.
REQ-029 SHALL discard in-flight operations on reset mid-operation; no result emitted for them.
REQ-030 SHALL assert in_ready = 1 during and after reset (pipeline empty).

Structure
REQ-031 SHALL place op encodings (OP_ADD, OP_SUB, OP_ADC, OP_SBC) in shared package alu_pkg.
REQ-032 SHALL use one combinational sub-module add_chunk (CHUNK-bit carry-lookahead adder: a, b, cin -> sum, cout, carry into MSB), instantiated once per stage via generate.

Verification
REQ-033 SHALL cover ADD 0x0000_0005 + 0x0000_0003, out_ready = 1 -> sum 0x8, cout 0, ovf 0, zero 0, exactly 4 cycles after acceptance.
REQ-034 SHALL cover SUB 0x8000_0000 - 0x0000_0001 -> sum 0x7FFF_FFFF, cout 1, ovf 1; SUB 0x3 - 0x3 -> sum 0, zero 1, cout 1.
REQ-035 SHALL cover ADC 0xFFFF_FFFF + 0x0 with cin = 1 -> sum 0, cout 1, zero 1 (carry rippling across all stages).
REQ-036 SHALL cover back-to-back 8 ops with out_ready = 0 for cycles 5-7 -> in_ready drops, outputs held, no loss/duplication, order preserved.
REQ-037 SHALL cover rst_n = 0 for one cycle with 3 ops in flight -> out_valid stays 0, none emitted; next op after reset completes in 4 cycles.
REQ-038 SHALL cover random ops vs. reference model for WIDTH/STAGES = 32/4, 32/1, 64/8, 16/2.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op encodings and operand-conditioning helpers for the add/sub datapath.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_ADC = 2'd2,
    OP_SBC = 2'd3
  } op_e;

  // Subtracting ops feed the adder the one's complement of b.
  function automatic logic op_inv_b(input logic [1:0] op);
    return (op == OP_SUB) || (op == OP_SBC);
  endfunction

  // Carry into the LSB: ADD 0, SUB 1 (completes two's complement), ADC/SBC take cin.
  function automatic logic op_carry(input logic [1:0] op, input logic cin);
    case (op)
      OP_ADD:  return 1'b0;
      OP_SUB:  return 1'b1;
      default: return cin;
    endcase
  endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational W-bit carry-lookahead adder slice; also exposes the carry into its MSB.
module add_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  logic [W-1:0] w_g, w_p;
  logic [W:0]   w_c;
  logic         w_acc, w_prod;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Each carry is the flat lookahead term g[i] | p[i]g[i-1] | ... | p[i..0]cin.
  always_comb begin
    w_c    = '0;
    w_acc  = 1'b0;
    w_prod = 1'b0;
    w_c[0] = cin;
    for (int i = 0; i < W; i++) begin
      w_acc  = w_g[i];
      w_prod = w_p[i];
      for (int j = i - 1; j >= 0; j--) begin
        w_acc  = w_acc | (w_prod & w_g[j]);
        w_prod = w_prod & w_p[j];
      end
      w_c[i+1] = w_acc | (w_prod & cin);
    end
  end

  assign sum   = w_p ^ w_c[W-1:0];
  assign cout  = w_c[W];
  assign c_msb = w_c[W-1];

endmodule

// File: rtl/pipe_add_sub.sv
// Chunked pipelined adder/subtractor: one CHUNK-bit slice per stage, LSB first,
// with a global stall when the output is held.
module pipe_add_sub
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipe_add_sub: WIDTH must be a positive multiple of STAGES");
  end

  localparam int CHUNK = WIDTH / STAGES;

  logic             w_adv, w_acc, w_c0;
  logic [WIDTH-1:0] w_bx;
  logic [STAGES:0]  w_vld_pipe;

  // Whole pipe moves together unless a finished result is waiting on the consumer.
  assign w_adv         = !w_vld_pipe[STAGES] || out_ready;
  assign in_ready      = w_adv;
  assign w_acc         = in_valid && w_adv;
  assign w_vld_pipe[0] = w_acc;
  assign w_bx          = op_inv_b(op) ? ~b : b;
  assign w_c0          = op_carry(op, cin);

  for (genvar s = 0; s < STAGES; s++) begin : g_st
    localparam int LO = s * CHUNK;

    logic [CHUNK-1:0]    w_a, w_b, w_sum;
    logic                w_ci, w_co, w_cm;
    logic [LO+CHUNK-1:0] w_s_nxt, r_s;
    logic                r_v, r_c;

    add_chunk #(.W(CHUNK)) u_add (
      .a(w_a), .b(w_b), .cin(w_ci), .sum(w_sum), .cout(w_co), .c_msb(w_cm)
    );

    if (s == 0) begin : g_head
      assign w_a     = a[CHUNK-1:0];
      assign w_b     = w_bx[CHUNK-1:0];
      assign w_ci    = w_c0;
      assign w_s_nxt = w_sum;
    end else begin : g_body
      assign w_a     = g_st[s-1].g_fwd.r_a[CHUNK-1:0];
      assign w_b     = g_st[s-1].g_fwd.r_b[CHUNK-1:0];
      assign w_ci    = g_st[s-1].r_c;
      assign w_s_nxt = {w_sum, g_st[s-1].r_s};
    end

    assign w_vld_pipe[s+1] = r_v;

    // Stage valid bit plus accumulated sum chunks and the carry out of this slice.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_s <= '0;
        r_c <= 1'b0;
      end else if (w_adv) begin
        r_v <= w_vld_pipe[s];
        if (w_vld_pipe[s]) begin
          r_s <= w_s_nxt;
          r_c <= w_co;
        end
      end
    end

    if (s < STAGES - 1) begin : g_fwd
      localparam int REM = WIDTH - LO - CHUNK;
      logic [REM-1:0] w_a_nxt, w_b_nxt, r_a, r_b;
      logic           w_unused_cm;

      // Only the top slice's MSB carry feeds the overflow flag.
      assign w_unused_cm = w_cm;

      if (s == 0) begin : g_src0
        assign w_a_nxt = a[WIDTH-1:CHUNK];
        assign w_b_nxt = w_bx[WIDTH-1:CHUNK];
      end else begin : g_srcn
        assign w_a_nxt = g_st[s-1].g_fwd.r_a[REM+CHUNK-1:CHUNK];
        assign w_b_nxt = g_st[s-1].g_fwd.r_b[REM+CHUNK-1:CHUNK];
      end

      // Carry the not-yet-added operand chunks to the next slice.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv && w_vld_pipe[s]) begin
          r_a <= w_a_nxt;
          r_b <= w_b_nxt;
        end
      end
    end else begin : g_last
      logic r_ovf, r_zero;

      // Flags are registered with the final slice so they reset to 0 with the sum.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_ovf  <= 1'b0;
          r_zero <= 1'b0;
        end else if (w_adv && w_vld_pipe[s]) begin
          r_ovf  <= w_cm ^ w_co;
          r_zero <= (w_s_nxt == '0);
        end
      end
    end
  end

  assign out_valid = w_vld_pipe[STAGES];
  assign sum       = g_st[STAGES-1].r_s;
  assign cout      = g_st[STAGES-1].r_c;
  assign ovf       = g_st[STAGES-1].g_last.r_ovf;
  assign zero      = g_st[STAGES-1].g_last.r_zero;

endmodule
